tsmac_tx_frame_feeder: RTL and testbench

Store-and-forward transmit feeder that sits directly upstream of the TSMAC core's system transmit interface (tdata/tstart/tlast, tpnd/tprt/tpar). It accepts one frame at a time from a valid/ready byte stream into a local buffer. It then replays that frame to the MAC under tpnd pacing. Because it keeps the whole frame, a MAC retry (tprt, half-duplex collision) rewinds and resends the frame without involving the user side.

---
 rtl/tsmac_tx_frame_feeder_pkg.sv | 16 +
 rtl/tsmac_tx_frame_ram.sv | 36 +++
 rtl/tsmac_tx_frame_feeder.sv | 181 ++++++++++++++++++
 tb/tb_tsmac_tx_frame_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsmac_tx_frame_feeder_pkg.sv
// rtl/tsmac_tx_frame_feeder_pkg.sv - shared constants and state encoding for the TSMAC transmit frame feeder
package tsmac_tx_frame_feeder_pkg;

    // 2048-byte buffer holds a full 1518-byte Ethernet frame.
    localparam int DEFAULT_WR_ADDR_WIDTH = 11;
    localparam int DEFAULT_CNT_WIDTH     = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_DROP      = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/tsmac_tx_frame_ram.sv
// rtl/tsmac_tx_frame_ram.sv - 8-bit simple dual-port frame buffer, synchronous write-first read
//
// Ports:
//   clk      - single clock for both ports
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write byte
//   rd_addr  - read address, registered into rd_data on the next edge
//   rd_data  - byte at the address presented on the previous cycle
module tsmac_tx_frame_ram #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem [1 << ADDR_WIDTH];

    // Write-first: a 1-byte frame writes address 0 in the same cycle the
    // feeder starts reading address 0 for its first SEND cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tsmac_tx_frame_feeder.sv
// rtl/tsmac_tx_frame_feeder.sv - store-and-forward transmit feeder for the TSMAC system transmit interface
//
// Ports:
//   tx_clki, tx_rst         - MAC transmit clock, async active-high reset
//   txceni                  - transmit clock enable gating MAC transfers
//   s_data/s_valid/s_last/s_ready - user byte stream into the frame buffer
//   tdata/tstart/tlast      - byte, first and last markers presented to the MAC
//   tpnd/tprt/tpar          - MAC data request, retry pulse, frame end/abort pulse
//   busy                    - block not in IDLE
//   frame_drop/frame_abort  - one-cycle event pulses (overflowed frame, early tpar)
//   frames_sent/retry_cnt   - wrapping statistics counters
module tsmac_tx_frame_feeder
    import tsmac_tx_frame_feeder_pkg::*;
#(
    parameter int WR_ADDR_WIDTH = DEFAULT_WR_ADDR_WIDTH,
    parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
    input  logic                 tx_clki,
    input  logic                 tx_rst,
    input  logic                 txceni,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [7:0]           tdata,
    output logic                 tstart,
    output logic                 tlast,
    input  logic                 tpnd,
    input  logic                 tprt,
    input  logic                 tpar,
    output logic                 busy,
    output logic                 frame_drop,
    output logic                 frame_abort,
    output logic [CNT_WIDTH-1:0] frames_sent,
    output logic [CNT_WIDTH-1:0] retry_cnt
);

    localparam logic [WR_ADDR_WIDTH-1:0] WR_ONE  = WR_ADDR_WIDTH'(1);
    localparam logic [WR_ADDR_WIDTH-1:0] WR_LAST = '1;
    localparam logic [WR_ADDR_WIDTH:0]   LEN_ONE = (WR_ADDR_WIDTH + 1)'(1);
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE = CNT_WIDTH'(1);

    state_t                 state, state_nxt;
    logic [WR_ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
    logic [WR_ADDR_WIDTH:0]   rd_ptr, rd_ptr_nxt;
    logic [WR_ADDR_WIDTH:0]   len, len_nxt;
    logic                   wr_en;
    logic [7:0]             rd_data;
    logic                   accept, xfer, in_send, at_last;
    logic                   drop_nxt, abort_nxt, sent_inc, retry_inc;

    assign in_send = (state == ST_SEND);
    assign s_ready = !tx_rst && ((state == ST_IDLE) || (state == ST_LOAD) || (state == ST_DROP));
    assign accept  = s_valid && s_ready;
    assign xfer    = tpnd && txceni;
    assign at_last = (rd_ptr == (len - LEN_ONE));
    assign busy    = (state != ST_IDLE);

    assign tdata   = in_send ? rd_data : 8'h00;
    assign tstart  = in_send && (rd_ptr == '0);
    assign tlast   = in_send && at_last;

    // Reading at rd_ptr_nxt keeps rd_data aligned with rd_ptr, so the byte
    // is ready on the first SEND cycle and after every transfer or rewind.
    tsmac_tx_frame_ram #(
        .ADDR_WIDTH (WR_ADDR_WIDTH)
    ) u_ram (
        .clk     (tx_clki),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (s_data),
        .rd_addr (rd_ptr_nxt[WR_ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        len_nxt    = len;
        wr_en      = 1'b0;
        drop_nxt   = 1'b0;
        abort_nxt  = 1'b0;
        sent_inc   = 1'b0;
        retry_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (s_last) begin
                        len_nxt    = LEN_ONE;
                        rd_ptr_nxt = '0;
                        state_nxt  = ST_SEND;
                    end else begin
                        wr_ptr_nxt = wr_ptr + WR_ONE;
                        state_nxt  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (s_last) begin
                        len_nxt    = {1'b0, wr_ptr} + LEN_ONE;
                        rd_ptr_nxt = '0;
                        state_nxt  = ST_SEND;
                    end else if (wr_ptr == WR_LAST) begin
                        state_nxt  = ST_DROP;
                    end else begin
                        wr_ptr_nxt = wr_ptr + WR_ONE;
                    end
                end
            end
            ST_DROP: begin
                if (accept && s_last) begin
                    drop_nxt   = 1'b1;
                    wr_ptr_nxt = '0;
                    state_nxt  = ST_IDLE;
                end
            end
            ST_SEND: begin
                // tpar beats tprt, and tprt beats a transfer in the same cycle.
                if (tpar) begin
                    abort_nxt  = 1'b1;
                    wr_ptr_nxt = '0;
                    state_nxt  = ST_IDLE;
                end else if (tprt) begin
                    rd_ptr_nxt = '0;
                    retry_inc  = 1'b1;
                end else if (xfer) begin
                    rd_ptr_nxt = rd_ptr + LEN_ONE;
                    if (at_last) begin
                        state_nxt = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (tpar) begin
                    sent_inc   = 1'b1;
                    wr_ptr_nxt = '0;
                    state_nxt  = ST_IDLE;
                end else if (tprt) begin
                    rd_ptr_nxt = '0;
                    retry_inc  = 1'b1;
                    state_nxt  = ST_SEND;
                end
            end
            default: begin
                wr_ptr_nxt = '0;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge tx_clki or posedge tx_rst) begin
        if (tx_rst) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            len         <= '0;
            frame_drop  <= 1'b0;
            frame_abort <= 1'b0;
            frames_sent <= '0;
            retry_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            len         <= len_nxt;
            frame_drop  <= drop_nxt;
            frame_abort <= abort_nxt;
            if (sent_inc) begin
                frames_sent <= frames_sent + CNT_ONE;
            end
            if (retry_inc) begin
                retry_cnt <= retry_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_tsmac_tx_frame_feeder.sv
// tb/tb_tsmac_tx_frame_feeder.sv - scoreboard testbench for the TSMAC transmit frame feeder
module tb_tsmac_tx_frame_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        txceni = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  tdata;
    logic        tstart, tlast;
    logic        tpnd = 1'b0;
    logic        tprt = 1'b0;
    logic        tpar = 1'b0;
    logic        busy, frame_drop, frame_abort;
    logic [15:0] frames_sent, retry_cnt;

    always #5 clk = ~clk;

    tsmac_tx_frame_feeder #(
        .WR_ADDR_WIDTH (11),
        .CNT_WIDTH     (16)
    ) dut (
        .tx_clki     (clk),
        .tx_rst      (rst),
        .txceni      (txceni),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .tdata       (tdata),
        .tstart      (tstart),
        .tlast       (tlast),
        .tpnd        (tpnd),
        .tprt        (tprt),
        .tpar        (tpar),
        .busy        (busy),
        .frame_drop  (frame_drop),
        .frame_abort (frame_abort),
        .frames_sent (frames_sent),
        .retry_cnt   (retry_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       st;
        logic       la;
    } xfer_t;

    xfer_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    drop_seen = 0;
    int    tstart_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       pat = i[7:0];
            1:       pat = 8'hA5;
            2:       pat = 8'(i * 3 + 7);
            default: pat = i[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Monitor: every MAC transfer cycle pops one expected byte.
    always @(negedge clk) begin : monitor
        xfer_t e;
        if (!rst) begin
            if (frame_drop) drop_seen++;
            if (tstart) tstart_seen++;
            if (tpnd && txceni && !tprt && !tpar && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("xfer", {22'd0, tdata, tstart, tlast}, {22'd0, e.d, e.st, e.la});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] d, input logic last);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) check("s_ready_timeout", {31'd0, s_ready}, 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic load_frame(input int n, input int kind, input bit push);
        for (int i = 0; i < n; i++) begin
            if (push) exp_q.push_back('{pat(kind, i), (i == 0), (i == n - 1)});
            put_byte(pat(kind, i), (i == n - 1));
        end
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (exp_q.size() > 0 && t < budget) begin
            tick();
            t++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_q(input int remaining, input int budget);
        int t = 0;
        while (exp_q.size() > remaining && t < budget) begin
            tick();
            t++;
        end
        if (exp_q.size() != remaining) check("wait_q_timeout", exp_q.size(), remaining);
    endtask

    task automatic finish_frame(input int exp_sent);
        tpnd = 1'b0;
        check("wait_done_busy", {31'd0, busy}, 32'd1);
        check("wait_done_outputs_zero", {22'd0, tdata, tstart, tlast}, 32'd0);
        tpar = 1'b1;
        tick();
        tpar = 1'b0;
        check("frames_sent", {16'd0, frames_sent}, exp_sent);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_s_ready", {31'd0, s_ready}, 32'd1);
    endtask

    initial begin
        int ts0, ds0, nrdy, c;

        // Reset state
        tick();
        tick();
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mac_out", {22'd0, tdata, tstart, tlast}, 32'd0);
        check("rst_counters", {frames_sent, retry_cnt}, 32'd0);
        check("rst_pulses", {30'd0, frame_drop, frame_abort}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        // 64-byte frame, tpnd held high
        load_frame(64, 0, 1);
        tpnd = 1'b1;
        drain(500);
        finish_frame(1);

        // 1-byte frame
        load_frame(1, 1, 1);
        tpnd = 1'b1;
        drain(50);
        finish_frame(2);

        // 60-byte frame, retry after 20 transfers (retry cycle also carries tpnd)
        load_frame(60, 2, 1);
        tpnd = 1'b1;
        wait_q(40, 200);
        tprt = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 60; i++) exp_q.push_back('{pat(2, i), (i == 0), (i == 59)});
        tick();
        tprt = 1'b0;
        drain(500);
        finish_frame(3);
        check("retry_cnt_after_retry", {16'd0, retry_cnt}, 32'd1);

        // Overflow: 2100 bytes, s_last on the final one
        ts0  = tstart_seen;
        ds0  = drop_seen;
        nrdy = 0;
        for (int i = 0; i < 2100; i++) begin
            if (!s_ready) nrdy++;
            put_byte(8'(i), (i == 2099));
        end
        check("drop_pulse", {31'd0, frame_drop}, 32'd1);
        check("drop_idle", {31'd0, busy}, 32'd0);
        tick();
        check("drop_pulse_once", drop_seen - ds0, 32'd1);
        check("drop_no_tstart", tstart_seen - ts0, 32'd0);
        check("drop_stalls", nrdy, 32'd0);
        check("drop_pulse_clear", {31'd0, frame_drop}, 32'd0);
        check("drop_frames_sent", {16'd0, frames_sent}, 32'd3);

        // Abort at byte 10 of a 100-byte frame
        load_frame(100, 3, 1);
        tpnd = 1'b1;
        wait_q(90, 200);
        tpar = 1'b1;
        tick();
        tpar = 1'b0;
        tpnd = 1'b0;
        exp_q.delete();
        check("abort_pulse", {31'd0, frame_abort}, 32'd1);
        check("abort_s_ready", {31'd0, s_ready}, 32'd1);
        check("abort_frames_sent", {16'd0, frames_sent}, 32'd3);
        tick();
        check("abort_pulse_clear", {31'd0, frame_abort}, 32'd0);

        // Simultaneous tprt and tpar in SEND
        load_frame(5, 0, 0);
        tprt = 1'b1;
        tpar = 1'b1;
        tick();
        tprt = 1'b0;
        tpar = 1'b0;
        check("simul_idle", {31'd0, busy}, 32'd0);
        check("simul_retry_cnt", {16'd0, retry_cnt}, 32'd1);
        check("simul_abort", {31'd0, frame_abort}, 32'd1);
        check("simul_frames_sent", {16'd0, frames_sent}, 32'd3);

        // Sparse clock enable with toggling tpnd
        load_frame(12, 2, 1);
        c = 0;
        while (exp_q.size() > 0 && c < 3000) begin
            txceni = (c % 10 == 0);
            tpnd   = ((c / 3) % 2 == 0);
            tick();
            c++;
        end
        txceni = 1'b1;
        if (exp_q.size() > 0) begin
            check("sparse_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        finish_frame(4);

        // Reset in the middle of SEND
        load_frame(30, 0, 1);
        tpnd = 1'b1;
        wait_q(25, 200);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        check("midrst_mac_out", {22'd0, tdata, tstart, tlast}, 32'd0);
        check("midrst_counters", {frames_sent, retry_cnt}, 32'd0);
        tick();
        rst  = 1'b0;
        tpnd = 1'b0;
        tick();
        check("post_midrst_s_ready", {31'd0, s_ready}, 32'd1);

        // Normal frame after the reset
        load_frame(4, 3, 1);
        tpnd = 1'b1;
        drain(50);
        finish_frame(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
